ohm_div_sched: RTL and testbench



---
 rtl/ohm_div_sched.sv | 187 ++++++++++++++++++
 tb/tb_ohm_div_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ohm_div_sched.sv
// ohm_div_sched: time-shares one resistance divider between NCH igniter sense channels.
// Latency: sample to div_valid 2 cycles when idle; one operation per DIV_LAT+2 cycles.
// Backpressure: none; a full holding buffer is overwritten (latest wins) and counted as an overrun.
// Optional: define OHM_SCHED_PRIO_EN to give channel 0 strict priority over the round-robin.
module ohm_div_sched #(
    parameter int NCH     = 4,
    parameter int DIV_LAT = 17,
    parameter int OVR_W   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NCH-1:0]       i_smp_valid,
    input  logic [NCH*12-1:0]    i_smp_v,
    input  logic [NCH*12-1:0]    i_smp_i,
    output logic                 o_div_valid,
    output logic [11:0]          o_div_v,
    output logic [11:0]          o_div_i,
    input  logic                 i_div_valid_out,
    input  logic [11:0]          i_div_r,
    output logic [NCH-1:0]       o_res_valid,
    output logic [11:0]          o_res_r,
    output logic                 o_res_lowi,
    output logic [NCH*OVR_W-1:0] o_ovr_cnt,
    output logic                 o_busy
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = $clog2(DIV_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_tag;
    logic [IDX_W-1:0]     r_rr;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_div_valid;
    logic [11:0]          r_div_v;
    logic [11:0]          r_div_i;
    logic [NCH-1:0]       r_res_valid;
    logic [11:0]          r_res_r;
    logic                 r_res_lowi;
    logic                 r_busy;

    logic [NCH-1:0]       r_pend;
    logic [11:0]          r_bv  [NCH];
    logic [11:0]          r_bi  [NCH];
    logic [OVR_W-1:0]     r_ovr [NCH];

    logic                 w_any;
    logic [IDX_W-1:0]     w_sel;
    logic [IDX_W-1:0]     w_rr_nxt;
    logic [NCH-1:0]       w_take;

    // Pick the first pending channel at or after rr in wrap order (channel 0 first when prioritised)
    always_comb begin
        logic [IDX_W:0] w_idx;
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = {1'b0, r_rr} + (IDX_W+1)'(k);
            if (w_idx >= (IDX_W+1)'(NCH)) begin
                w_idx = w_idx - (IDX_W+1)'(NCH);
            end
`ifdef OHM_SCHED_PRIO_EN
            if (!w_any && r_pend[w_idx[IDX_W-1:0]] && (w_idx != '0)) begin
`else
            if (!w_any && r_pend[w_idx[IDX_W-1:0]]) begin
`endif
                w_any = 1'b1;
                w_sel = w_idx[IDX_W-1:0];
            end
        end
`ifdef OHM_SCHED_PRIO_EN
        if (r_pend[0]) begin
            w_any = 1'b1;
            w_sel = '0;
        end
`endif
    end

    // Buffer is handed to the divider on the IDLE->ISSUE edge; rr advances past the grant
    always_comb begin
        w_take   = '0;
        w_rr_nxt = (w_sel == IDX_W'(NCH - 1)) ? '0 : w_sel + 1'b1;
        if ((r_state == S_IDLE) && w_any) begin
            w_take[w_sel] = 1'b1;
        end
    end

    // Per-channel holding buffers; a sample landing on the take edge refills without an overrun
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                r_bv[ch]  <= '0;
                r_bi[ch]  <= '0;
                r_ovr[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (i_smp_valid[ch]) begin
                    r_bv[ch]   <= i_smp_v[ch*12 +: 12];
                    r_bi[ch]   <= i_smp_i[ch*12 +: 12];
                    r_pend[ch] <= 1'b1;
                    if (r_pend[ch] && !w_take[ch] && (r_ovr[ch] != '1)) begin
                        r_ovr[ch] <= r_ovr[ch] + 1'b1;
                    end
                end else if (w_take[ch]) begin
                    r_pend[ch] <= 1'b0;
                end
            end
        end
    end

    // Scheduler FSM with registered divider and result outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_tag       <= '0;
            r_rr        <= '0;
            r_cnt       <= '0;
            r_div_valid <= 1'b0;
            r_div_v     <= '0;
            r_div_i     <= '0;
            r_res_valid <= '0;
            r_res_r     <= 12'h7FF;
            r_res_lowi  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_div_valid <= 1'b0;
            r_res_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_tag       <= w_sel;
                        r_div_valid <= 1'b1;
                        r_div_v     <= r_bv[w_sel];
                        r_div_i     <= r_bi[w_sel];
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
`ifdef OHM_SCHED_PRIO_EN
                        if (w_sel != '0) begin
                            r_rr <= w_rr_nxt;
                        end
`else
                        r_rr <= w_rr_nxt;
`endif
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= CNT_W'(1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Only the divider's result cycle is observed; stray valid_out is ignored
                    if (r_cnt == CNT_W'(DIV_LAT)) begin
                        r_res_valid <= NCH'(1) << r_tag;
                        r_res_r     <= i_div_valid_out ? i_div_r : 12'h7FF;
                        r_res_lowi  <= !i_div_valid_out;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ovr
        assign o_ovr_cnt[g*OVR_W +: OVR_W] = r_ovr[g];
    end

    assign o_div_valid = r_div_valid;
    assign o_div_v     = r_div_v;
    assign o_div_i     = r_div_i;
    assign o_res_valid = r_res_valid;
    assign o_res_r     = r_res_r;
    assign o_res_lowi  = r_res_lowi;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_ohm_div_sched.sv
// Testbench for ohm_div_sched with a model divider and an issue/result scoreboard.
// Stimulus drives just after posedge; monitor samples on negedge.
// Expectations are hand-computed and pushed when stimulus is issued.
module tb_ohm_div_sched;
    localparam int NCH = 4, DIV_LAT = 17, OVR_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NCH-1:0]       smp_valid;
    logic [NCH*12-1:0]    smp_v, smp_i;
    logic                 div_valid;
    logic [11:0]          div_v, div_i;
    logic                 div_vo;
    logic [11:0]          div_r;
    logic [NCH-1:0]       res_valid;
    logic [11:0]          res_r;
    logic                 res_lowi;
    logic [NCH*OVR_W-1:0] ovr_cnt;
    logic                 busy;

    always #5 clk = ~clk;

    ohm_div_sched #(.NCH(NCH), .DIV_LAT(DIV_LAT), .OVR_W(OVR_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_smp_valid(smp_valid), .i_smp_v(smp_v), .i_smp_i(smp_i),
        .o_div_valid(div_valid), .o_div_v(div_v), .o_div_i(div_i),
        .i_div_valid_out(div_vo), .i_div_r(div_r),
        .o_res_valid(res_valid), .o_res_r(res_r), .o_res_lowi(res_lowi),
        .o_ovr_cnt(ovr_cnt), .o_busy(busy)
    );

    int n_chk = 0, n_pass = 0, cyc = 0;
    logic [23:0] q_iss[$];
    logic [16:0] q_res[$];
    bit sb_skip = 0, spc_en = 0, have_last = 0;
    int last_iss = 0;
    bit model_ok = 1, stray_en = 0;
    logic [11:0] model_r = 12'h000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tmo(input string name);
        n_chk++;
        $display("FAIL %s: bound expired, expected DUT event", name);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [23:0] ei;
        logic [16:0] er;
        if (rst_n && !sb_skip) begin
            if (div_valid) begin
                if (spc_en && have_last) chk("issue_spacing", 32'(cyc - last_iss), DIV_LAT + 2);
                last_iss  = cyc;
                have_last = 1;
                if (q_iss.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_issue: got v=%h i=%h, expected none", div_v, div_i);
                end else begin
                    ei = q_iss.pop_front();
                    chk("issue_data", {8'h0, div_v, div_i}, {8'h0, ei});
                end
            end
            if (res_valid != '0) begin
                if (q_res.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_result: got vld=%b r=%h lowi=%b, expected none", res_valid, res_r, res_lowi);
                end else begin
                    er = q_res.pop_front();
                    chk("result", {15'h0, res_valid, res_r, res_lowi}, {15'h0, er});
                end
            end
        end
    end

    // Model divider: result cycle DIV_LAT after div_valid, optional stray pulse at DIV_LAT+3
    initial begin
        div_vo = 1'b0;
        div_r  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && div_valid) begin
                repeat (DIV_LAT) @(posedge clk);
                #1;
                if (model_ok) begin div_vo = 1'b1; div_r = model_r; end
                else div_r = 12'hBAD;
                @(posedge clk); #1 div_vo = 1'b0;
                if (stray_en) begin
                    repeat (2) @(posedge clk);
                    #1 div_vo = 1'b1; div_r = 12'h155;
                    @(posedge clk); #1 div_vo = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set(input int ch, input logic [11:0] v, input logic [11:0] i);
        smp_valid[ch]       = 1'b1;
        smp_v[ch*12 +: 12]  = v;
        smp_i[ch*12 +: 12]  = i;
    endtask

    task automatic post(input int ch, input logic [11:0] v, input logic [11:0] i);
        set(ch, v, i);
        tick();
        smp_valid = '0;
    endtask

    task automatic expect_op(input int ch, input logic [11:0] v, input logic [11:0] i,
                             input logic [11:0] r, input logic lowi);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        q_iss.push_back({v, i});
        q_res.push_back({oh, r, lowi});
    endtask

    task automatic wait_issue();
        int n = 0;
        while (!div_valid && n < 100) begin @(negedge clk); n++; end
        if (!div_valid) tmo("wait_issue");
    endtask

    task automatic wait_quiet();
        int q = 0, n = 0;
        while (q < 3 && n < 200) begin
            tick();
            n++;
            q = busy ? 0 : q + 1;
        end
        if (q < 3) tmo("wait_quiet");
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        smp_valid = '0; smp_v = '0; smp_i = '0;
        rst_n = 1'b0;
        tick(3);
        chk("rst_div_valid", div_valid, 0);
        chk("rst_div_vi", {div_v, div_i}, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_r", res_r, 12'h7FF);
        chk("rst_res_lowi", res_lowi, 0);
        chk("rst_ovr_cnt", ovr_cnt, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(2);

        // Fairness from rr=0 with back-to-back spacing of DIV_LAT+2
        model_ok = 1; model_r = 12'h321; spc_en = 1; have_last = 0;
`ifdef OHM_SCHED_PRIO_EN
        expect_op(0, 12'h0A5, 12'h05A, 12'h321, 0);
        for (int k = 1; k <= 3; k++) expect_op(0, 12'hE00 + 12'(k), 12'h0E0, 12'h321, 0);
        for (int k = 1; k < NCH; k++) expect_op(k, {4'(k), 8'hA5}, {4'(k), 8'h5A}, 12'h321, 0);
        for (int k = 0; k < NCH; k++) set(k, {4'(k), 8'hA5}, {4'(k), 8'h5A});
        tick(); smp_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            wait_issue(); tick(3);
            post(0, 12'hE00 + 12'(k), 12'h0E0);
        end
`else
        for (int k = 0; k < NCH; k++) expect_op(k, {4'(k), 8'hA5}, {4'(k), 8'h5A}, 12'h321, 0);
        expect_op(0, 12'hE0E, 12'h0E0, 12'h321, 0);
        for (int k = 0; k < NCH; k++) set(k, {4'(k), 8'hA5}, {4'(k), 8'h5A});
        tick(); smp_valid = '0;
        wait_issue(); tick(3);
        post(0, 12'hE0E, 12'h0E0);
`endif
        wait_quiet();
        spc_en = 0;
        chk("fair_ovr0", ovr_cnt[0 +: 8], 0);

        // Single sample on ch2
        model_r = 12'h6A0;
        expect_op(2, 12'h3FF, 12'h5FF, 12'h6A0, 0);
        post(2, 12'h3FF, 12'h5FF);
        chk("single_no_early_issue", div_valid, 0);
        tick();
        chk("single_issue_cycle", div_valid, 1);
        wait_quiet();
        tick(5);
        chk("res_r_hold", res_r, 12'h6A0);
        chk("res_valid_idle", res_valid, 0);

        // Low current: no valid_out at the result cycle, stray pulse afterwards
        model_ok = 0; stray_en = 1;
        expect_op(1, 12'h123, 12'h010, 12'h7FF, 1);
        post(1, 12'h123, 12'h010);
        wait_quiet();
        tick(8);
        chk("lowi_hold_r", res_r, 12'h7FF);
        chk("lowi_hold_flag", res_lowi, 1);
        chk("lowi_stray_busy", busy, 0);
        stray_en = 0; model_ok = 1;

        // Overrun: ch1 posts three times while ch3 is in flight
        model_r = 12'h2B2;
        expect_op(3, 12'h301, 12'h031, 12'h2B2, 0);
        expect_op(1, 12'h333, 12'h033, 12'h2B2, 0);
        post(3, 12'h301, 12'h031);
        wait_issue(); tick(2);
        post(1, 12'h111, 12'h011);
        post(1, 12'h222, 12'h022);
        post(1, 12'h333, 12'h033);
        wait_quiet();
        chk("ovr1_count", ovr_cnt[8 +: 8], 2);
        chk("ovr3_zero", ovr_cnt[24 +: 8], 0);

        // Saturation: continuous posting on ch1
        sb_skip = 1;
        set(1, 12'h0AA, 12'h0BB);
        tick(320);
        smp_valid = '0;
        wait_quiet();
        sb_skip = 0;
        chk("ovr1_saturate", ovr_cnt[8 +: 8], 8'hFF);
        chk("ovr_others", {ovr_cnt[0 +: 8], ovr_cnt[16 +: 8], ovr_cnt[24 +: 8]}, 0);

        // Sample lands on ch3 during its ISSUE cycle
        expect_op(3, 12'hA01, 12'h0A1, 12'h2B2, 0);
        expect_op(3, 12'hA02, 12'h0A2, 12'h2B2, 0);
        post(3, 12'hA01, 12'h0A1);
        tick();
        chk("simul_issue_cycle", div_valid, 1);
        post(3, 12'hA02, 12'h0A2);
        wait_quiet();
        chk("simul_ovr3", ovr_cnt[24 +: 8], 0);

        // Reset at WAIT counter 8 abandons the operation
        q_iss.push_back({12'h0C3, 12'h03C});
        post(0, 12'h0C3, 12'h03C);
        wait_issue();
        tick(8);
        rst_n = 1'b0;
        #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_div_valid", div_valid, 0);
        chk("rstw_res", {res_valid, res_r, res_lowi}, {4'b0, 12'h7FF, 1'b0});
        chk("rstw_ovr", ovr_cnt, 0);
        tick(2);
        rst_n = 1'b1;
        tick(15);
        chk("rstw_no_result", res_valid, 0);
        chk("rstw_idle", busy, 0);
        model_r = 12'h4C4;
        expect_op(2, 12'h456, 12'h045, 12'h4C4, 0);
        post(2, 12'h456, 12'h045);
        wait_quiet();

        chk("iss_q_drained", q_iss.size(), 0);
        chk("res_q_drained", q_res.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
